// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Accepts one operation per Start pulse, holds Busy for a fixed latency, then commits HI/LO.
module mul_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] MDU_D1,
  input  logic [31:0] MDU_D2,
  input  logic [31:0] WrHL,
  input  logic        HI_En,
  input  logic        LO_En,
  input  logic [1:0]  MDU_Sel,
  input  logic        Start,
  input  logic        HaveIntOrExc,
  output logic [31:0] R_HI,
  output logic [31:0] R_LO,
  output logic        Busy
);

  localparam int unsigned W    = 32;
  localparam int unsigned CntW = 5;

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0]    op_a_q, op_a_d, op_b_q, op_b_d;
  logic [1:0]      sel_q, sel_d;

  logic            accept;
  logic            is_div, is_signed, a_neg, b_neg, div_by_zero;
  logic [W-1:0]    mag_a, mag_b, quot_mag, rem_mag, quot, rem;
  logic [2*W-1:0]  ext_a, ext_b, prod;

  // Result datapath, evaluated from the captured operands
  always_comb begin
    is_div      = sel_q[1];
    is_signed   = ~sel_q[0];
    ext_a       = is_signed ? {{W{op_a_q[W-1]}}, op_a_q} : {{W{1'b0}}, op_a_q};
    ext_b       = is_signed ? {{W{op_b_q[W-1]}}, op_b_q} : {{W{1'b0}}, op_b_q};
    prod        = ext_a * ext_b;
    a_neg       = is_signed & op_a_q[W-1];
    b_neg       = is_signed & op_b_q[W-1];
    mag_a       = a_neg ? W'(-op_a_q) : op_a_q;
    mag_b       = b_neg ? W'(-op_b_q) : op_b_q;
    div_by_zero = (op_b_q == '0);
    quot_mag    = div_by_zero ? '0 : mag_a / mag_b;
    rem_mag     = div_by_zero ? '0 : mag_a % mag_b;
    // Quotient truncates toward zero; remainder follows the dividend's sign
    quot        = (a_neg ^ b_neg) ? W'(-quot_mag) : quot_mag;
    rem         = a_neg ? W'(-rem_mag) : rem_mag;
  end

  assign accept = Start & ~HaveIntOrExc;

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_a_d  = MDU_D1;
          op_b_d  = MDU_D2;
          sel_d   = MDU_Sel;
          cnt_d   = MDU_Sel[1] ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else if (~HaveIntOrExc) begin
          if (HI_En) hi_d = WrHL;
          if (LO_En) lo_d = WrHL;
        end
      end
      ST_RUN: begin
        if (cnt_q == CntW'(1)) begin
          if (!is_div) begin
            hi_d = prod[2*W-1:W];
            lo_d = prod[W-1:0];
          end else if (!div_by_zero) begin
            hi_d = rem;
            lo_d = quot;
          end
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sel_q   <= sel_d;
    end
  end

  assign R_HI = hi_q;
  assign R_LO = lo_q;
  assign Busy = busy_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: constant vector table, corner-case sequences and
// randomized operations checked against a plain-arithmetic reference model.
module tb_mul_div_unit;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        Clk, Rst;
  logic [31:0] MDU_D1, MDU_D2, WrHL;
  logic        HI_En, LO_En, Start, HaveIntOrExc;
  logic [1:0]  MDU_Sel;
  logic [31:0] R_HI, R_LO;
  logic        Busy;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  mul_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .Clk(Clk), .Rst(Rst), .MDU_D1(MDU_D1), .MDU_D2(MDU_D2), .WrHL(WrHL),
    .HI_En(HI_En), .LO_En(LO_En), .MDU_Sel(MDU_Sel), .Start(Start),
    .HaveIntOrExc(HaveIntOrExc), .R_HI(R_HI), .R_LO(R_LO), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: {HI,LO} from 64-bit integer arithmetic
  function automatic logic [63:0] ref_res(input logic [1:0] sel, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r, p;
    if (sel[0]) begin
      sa = {32'h0, a};
      sb = {32'h0, b};
    end else begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end
    if (!sel[1]) begin
      p = sa * sb;
      return p;
    end
    if (b == 32'h0) return {m_hi, m_lo};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic clear_inputs();
    Start = 1'b0; HI_En = 1'b0; LO_En = 1'b0; HaveIntOrExc = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after Busy falls
  task automatic run_op(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input bit noise, input bit wr_at_start);
    logic [63:0] exp;
    int n;
    int exp_n;
    exp   = ref_res(sel, a, b);
    exp_n = sel[1] ? DIV_N : MULT_N;
    Start = 1'b1; MDU_Sel = sel; MDU_D1 = a; MDU_D2 = b;
    if (wr_at_start) begin
      HI_En = 1'b1; LO_En = 1'b1; WrHL = $urandom;
    end
    @(negedge Clk);
    clear_inputs();
    MDU_D1 = $urandom; MDU_D2 = $urandom;
    n = 0;
    while (Busy === 1'b1 && n < 64) begin
      n++;
      chk("hold_during_run", {R_HI, R_LO}, {m_hi, m_lo});
      if (noise) begin
        HaveIntOrExc = (n == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        HI_En        = (n == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        LO_En        = (n == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        Start        = (n == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        MDU_Sel      = 2'($urandom);
        WrHL         = $urandom;
      end
      @(negedge Clk);
    end
    clear_inputs();
    chk("busy_len", 64'(n), 64'(exp_n));
    {m_hi, m_lo} = exp;
    chk("result", {R_HI, R_LO}, {m_hi, m_lo});
  endtask

  task automatic wr_direct(input bit hi_en, input bit lo_en, input bit exc, input logic [31:0] d);
    HI_En = hi_en; LO_En = lo_en; HaveIntOrExc = exc; WrHL = d;
    @(negedge Clk);
    clear_inputs();
    if (!exc) begin
      if (hi_en) m_hi = d;
      if (lo_en) m_lo = d;
    end
    chk("direct_write", {R_HI, R_LO}, {m_hi, m_lo});
    chk("direct_no_busy", 64'(Busy), 64'(0));
  endtask

  vec_t vecs[8];

  initial begin
    Rst = 1'b1;
    MDU_D1 = '0; MDU_D2 = '0; WrHL = '0; MDU_Sel = '0;
    clear_inputs();

    vecs[0] = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{2'b01, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA};
    vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4] = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[5] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[6] = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC};
    vecs[7] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

    #1;
    chk("reset_busy", 64'(Busy), 64'(0));
    chk("reset_hilo", {R_HI, R_LO}, 64'h0);
    @(negedge Clk);
    Rst = 1'b0;

    // Constant vectors, back-to-back on the cycle after Busy falls
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, 1'b0, 1'b0);
      chk("vec_hi", 64'(R_HI), 64'(vecs[i].hi));
      chk("vec_lo", 64'(R_LO), 64'(vecs[i].lo));
    end

    // mthi in idle, then divu by zero keeps HI/LO
    wr_direct(1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
    chk("mthi_value", 64'(R_HI), 64'(32'hDEADBEEF));
    wr_direct(1'b1, 1'b0, 1'b0, 32'h00000011);
    wr_direct(1'b0, 1'b1, 1'b0, 32'h00000022);
    run_op(2'b11, 32'h7, 32'h0, 1'b0, 1'b0);
    chk("div0_keep", {R_HI, R_LO}, {32'h11, 32'h22});

    // Exception blocks Start and direct writes
    Start = 1'b1; HaveIntOrExc = 1'b1; HI_En = 1'b1; LO_En = 1'b1; WrHL = 32'h12345678;
    MDU_Sel = 2'b00; MDU_D1 = 32'h3; MDU_D2 = 32'h3;
    @(negedge Clk);
    clear_inputs();
    chk("exc_no_start", 64'(Busy), 64'(0));
    chk("exc_no_write", {R_HI, R_LO}, {32'h11, 32'h22});
    @(negedge Clk);
    chk("exc_still_idle", 64'(Busy), 64'(0));
    wr_direct(1'b1, 1'b1, 1'b1, 32'hCAFEF00D);

    // Start + direct write same cycle, and noise (exc/Start/HI_En/LO_En) during RUN
    run_op(2'b00, 32'hFFFFFFFE, 32'h3, 1'b1, 1'b1);
    chk("start_wins_lo", 64'(R_LO), 64'(32'hFFFFFFFA));
    run_op(2'b10, 32'hFFFFFFF9, 32'h2, 1'b1, 1'b0);
    chk("exc_in_run_lo", 64'(R_LO), 64'(32'hFFFFFFFD));

    // Asynchronous reset in the middle of a divide
    Start = 1'b1; MDU_Sel = 2'b10; MDU_D1 = 32'h100; MDU_D2 = 32'h3;
    @(negedge Clk);
    clear_inputs();
    repeat (3) @(negedge Clk);
    chk("pre_reset_busy", 64'(Busy), 64'(1));
    #2 Rst = 1'b1;
    #1;
    chk("async_rst_busy", 64'(Busy), 64'(0));
    chk("async_rst_hilo", {R_HI, R_LO}, 64'h0);
    m_hi = '0; m_lo = '0;
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    chk("post_reset_idle", {31'h0, Busy, R_HI, R_LO}, 97'h0);

    // Randomized operations
    for (int k = 0; k < 150; k++) begin
      logic [1:0] s;
      logic [31:0] a, b;
      s = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      run_op(s, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      case ($urandom_range(0, 3))
        0: wr_direct(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom);
        1: @(negedge Clk);
        default: ;
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
